// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with delay, call/return stack and halt.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   enable            : 1 advances the sequencer, 0 freezes every register
//   pc_op             : 0 HOLD, 1 INC, 2 JUMP, 3 DELAY, 4 CALL, 5 RET, 6 HALT, 7 HOLD
//   new_address       : JUMP/CALL target
//   delay             : DELAY cycle count, held stable by control while delaying
//   address           : current PC (registered)
//   busy              : delay counter non-zero
//   halted            : sticky halt until reset
//   stack_depth       : valid return-stack entries
//   stack_overflow    : sticky, CALL seen with a full stack
//   stack_underflow   : sticky, RET seen with an empty stack
module pc_sequencer #(
    parameter int ADDR_W      = 20,
    parameter int DELAY_W     = 10,
    parameter int STACK_DEPTH = 8,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        pc_op,
    input  logic [ADDR_W-1:0] new_address,
    input  logic [DELAY_W-1:0] delay,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  stack_depth,
    output logic              stack_overflow,
    output logic              stack_underflow
);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_JUMP  = 3'd2;
    localparam logic [2:0] OP_DELAY = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;
    localparam logic [2:0] OP_HALT  = 3'd6;

    logic [ADDR_W-1:0]  stack [STACK_DEPTH];
    logic [DELAY_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0]  addr_n, addr_inc;
    logic [CNT_W-1:0]   depth_n;
    logic               halted_n, ovf_n, unf_n, push;
    logic               full, empty;
    logic [IDX_W-1:0]   push_idx, top_idx;

    assign addr_inc = address + 1'b1;
    assign full     = stack_depth == CNT_W'(STACK_DEPTH);
    assign empty    = stack_depth == '0;
    assign push_idx = IDX_W'(stack_depth);
    assign top_idx  = IDX_W'(stack_depth - 1'b1);
    assign busy     = cnt != '0;

    always_comb begin
        addr_n   = address;
        cnt_n    = cnt;
        halted_n = halted;
        depth_n  = stack_depth;
        ovf_n    = stack_overflow;
        unf_n    = stack_underflow;
        push     = 1'b0;
        if (enable && !halted) begin
            // every op except a continuing DELAY restarts the delay count
            cnt_n = '0;
            case (pc_op)
                OP_INC:   addr_n = addr_inc;
                OP_JUMP:  addr_n = new_address;
                OP_DELAY: begin
                    if (cnt != delay) cnt_n = cnt + 1'b1;
                    else addr_n = addr_inc;
                end
                OP_CALL: begin
                    if (full) ovf_n = 1'b1;
                    else begin
                        push    = 1'b1;
                        addr_n  = new_address;
                        depth_n = stack_depth + 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty) unf_n = 1'b1;
                    else begin
                        addr_n  = stack[top_idx];
                        depth_n = stack_depth - 1'b1;
                    end
                end
                OP_HALT:  halted_n = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            address         <= '0;
            cnt             <= '0;
            halted          <= 1'b0;
            stack_depth     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            address         <= addr_n;
            cnt             <= cnt_n;
            halted          <= halted_n;
            stack_depth     <= depth_n;
            stack_overflow  <= ovf_n;
            stack_underflow <= unf_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) stack[push_idx] <= addr_inc;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer (ADDR_W=20, STACK_DEPTH=2).
module tb_pc_sequencer;
    typedef struct packed {
        logic [19:0] a;
        logic        b;
        logic        h;
        logic [1:0]  d;
        logic        o;
        logic        u;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  pc_op = 3'd0;
    logic [19:0] new_address = '0;
    logic [9:0]  delay = '0;
    logic [19:0] address;
    logic        busy, halted, stack_overflow, stack_underflow;
    logic [1:0]  stack_depth;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;

    pc_sequencer #(.ADDR_W(20), .DELAY_W(10), .STACK_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .enable(enable), .pc_op(pc_op),
        .new_address(new_address), .delay(delay), .address(address), .busy(busy),
        .halted(halted), .stack_depth(stack_depth),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clock = ~clock;

    // Monitor: every edge that follows a driven cycle has one expected state queued.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e, g;
            e = exp_q.pop_front();
            g = '{address, busy, halted, stack_depth, stack_overflow, stack_underflow};
            step_no++;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL step%0d: got addr=%h busy=%b halt=%b depth=%0d ovf=%b unf=%b, want addr=%h busy=%b halt=%b depth=%0d ovf=%b unf=%b",
                         step_no, g.a, g.b, g.h, g.d, g.o, g.u, e.a, e.b, e.h, e.d, e.o, e.u);
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic [2:0] op,
                        input logic [19:0] na, input logic [9:0] dl,
                        input logic [19:0] ea, input logic eb, input logic eh,
                        input logic [1:0] ed, input logic eo, input logic eu);
        @(negedge clock);
        reset = r; enable = en; pc_op = op; new_address = na; delay = dl;
        exp_q.push_back('{ea, eb, eh, ed, eo, eu});
    endtask

    initial begin
        //    rst en op  new_addr  dly  addr      b  h  d  o  u
        step(1, 0, 3'd0, 20'h0,     0, 20'h0,     0, 0, 0, 0, 0);
        step(0, 1, 3'd1, 20'h0,     0, 20'h1,     0, 0, 0, 0, 0);
        step(0, 1, 3'd1, 20'h0,     0, 20'h2,     0, 0, 0, 0, 0);
        step(0, 1, 3'd1, 20'h0,     0, 20'h3,     0, 0, 0, 0, 0);
        step(0, 1, 3'd2, 20'hFFFFF, 0, 20'hFFFFF, 0, 0, 0, 0, 0);
        step(0, 1, 3'd1, 20'h0,     0, 20'h0,     0, 0, 0, 0, 0);
        step(0, 1, 3'd2, 20'h100,   0, 20'h100,   0, 0, 0, 0, 0);
        // delay=3: three holding edges, advance on the fourth
        step(0, 1, 3'd3, 20'h0,     3, 20'h100,   1, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     3, 20'h100,   1, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     3, 20'h100,   1, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     3, 20'h101,   0, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     3, 20'h101,   1, 0, 0, 0, 0);
        step(0, 1, 3'd0, 20'h0,     3, 20'h101,   0, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     0, 20'h102,   0, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     0, 20'h103,   0, 0, 0, 0, 0);
        // stall mid-delay for 4 cycles, then resume
        step(0, 1, 3'd3, 20'h0,     2, 20'h103,   1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 3'd3, 20'h0, 2, 20'h103,   1, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     2, 20'h103,   1, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     2, 20'h104,   0, 0, 0, 0, 0);
        // INC aborts a delay; the next delay restarts from zero
        step(0, 1, 3'd3, 20'h0,     2, 20'h104,   1, 0, 0, 0, 0);
        step(0, 1, 3'd1, 20'h0,     2, 20'h105,   0, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     2, 20'h105,   1, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     2, 20'h105,   1, 0, 0, 0, 0);
        step(0, 1, 3'd3, 20'h0,     2, 20'h106,   0, 0, 0, 0, 0);
        // nested call/return
        step(0, 1, 3'd2, 20'h10,    0, 20'h10,    0, 0, 0, 0, 0);
        step(0, 1, 3'd4, 20'h200,   0, 20'h200,   0, 0, 1, 0, 0);
        step(0, 1, 3'd4, 20'h300,   0, 20'h300,   0, 0, 2, 0, 0);
        step(0, 1, 3'd5, 20'h0,     0, 20'h201,   0, 0, 1, 0, 0);
        step(0, 1, 3'd5, 20'h0,     0, 20'h11,    0, 0, 0, 0, 0);
        // overflow on third call, underflow on extra return
        step(0, 1, 3'd4, 20'h400,   0, 20'h400,   0, 0, 1, 0, 0);
        step(0, 1, 3'd4, 20'h500,   0, 20'h500,   0, 0, 2, 0, 0);
        step(0, 1, 3'd4, 20'h600,   0, 20'h500,   0, 0, 2, 1, 0);
        step(0, 1, 3'd5, 20'h0,     0, 20'h401,   0, 0, 1, 1, 0);
        step(0, 1, 3'd5, 20'h0,     0, 20'h12,    0, 0, 0, 1, 0);
        step(0, 1, 3'd5, 20'h0,     0, 20'h12,    0, 0, 0, 1, 1);
        step(0, 0, 3'd4, 20'h700,   0, 20'h12,    0, 0, 0, 1, 1);
        // halt freezes everything until reset
        step(0, 1, 3'd6, 20'h0,     0, 20'h12,    0, 1, 0, 1, 1);
        step(0, 1, 3'd1, 20'h0,     0, 20'h12,    0, 1, 0, 1, 1);
        step(0, 1, 3'd2, 20'h55,    0, 20'h12,    0, 1, 0, 1, 1);
        step(0, 1, 3'd4, 20'h66,    0, 20'h12,    0, 1, 0, 1, 1);
        step(1, 0, 3'd1, 20'h0,     0, 20'h0,     0, 0, 0, 0, 0);
        step(0, 1, 3'd1, 20'h0,     0, 20'h1,     0, 0, 0, 0, 0);
        step(0, 1, 3'd7, 20'h77,    0, 20'h1,     0, 0, 0, 0, 0);
        step(0, 1, 3'd1, 20'h0,     0, 20'h2,     0, 0, 0, 0, 0);
        @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
